// File: rtl/clkdiv_gen.sv
// clkdiv_gen: programmable glitch-free clock divider with start-phase offset and period-boundary reconfiguration
module clkdiv_gen #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic             gclk,
    output logic             gclk_rise,
    output logic             locked
);
    typedef enum logic [1:0] {IDLE, PHASE, RUN} state_t;
    state_t           r_state, w_state;
    logic [DIV_W-1:0] r_div, r_phase, r_pdiv, r_pphase, r_cnt, r_pcnt;
    logic [DIV_W-1:0] w_div, w_phase, w_pdiv, w_pphase, w_cnt, w_pcnt;
    logic [DIV_W-1:0] w_cdiv, w_cphase, w_high;
    logic [1:0]       r_per, w_per;
    logic             r_pend, r_gclk, r_rise, r_locked;
    logic             w_pend, w_gclk, w_rise, w_locked;
    logic             w_fire, w_wrap, w_apply;
    assign cfg_ready = !r_pend;
    assign gclk      = r_gclk;
    assign gclk_rise = r_rise;
    assign locked    = r_locked;
    assign w_fire    = cfg_valid && cfg_ready;
    assign w_cdiv    = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    assign w_cphase  = (cfg_phase >= w_cdiv) ? w_cdiv - 1'b1 : cfg_phase;
    assign w_high    = (r_div >> 1) + {{(DIV_W-1){1'b0}}, r_div[0]};
    assign w_wrap    = (r_state == RUN) && (r_cnt == r_div - 1'b1);
    // a pending config lands at a period wrap, or when an aborted start falls back to idle
    assign w_apply   = r_pend && (w_wrap || (r_state == PHASE && !en));
    // next-state, counters, config bookkeeping and registered clock outputs
    always_comb begin
        w_state  = r_state;
        w_div    = r_div;
        w_phase  = r_phase;
        w_pend   = r_pend;
        w_pdiv   = r_pdiv;
        w_pphase = r_pphase;
        w_cnt    = r_cnt;
        w_pcnt   = r_pcnt;
        w_per    = r_per;
        w_locked = r_locked;
        w_gclk   = 1'b0;
        w_rise   = 1'b0;
        if (w_fire && r_state != IDLE) begin
            w_pend   = 1'b1;
            w_pdiv   = w_cdiv;
            w_pphase = w_cphase;
        end
        if (w_apply) begin
            w_pend  = 1'b0;
            w_div   = r_pdiv;
            w_phase = r_pphase;
        end
        case (r_state)
            IDLE: begin
                w_locked = 1'b0;
                if (w_fire) begin
                    w_div   = w_cdiv;
                    w_phase = w_cphase;
                end
                if (en) begin
                    w_state = PHASE;
                    w_pcnt  = w_fire ? w_cphase : r_phase;
                end
            end
            PHASE: begin
                if (!en) begin
                    w_state = IDLE;
                end else if (r_pcnt == '0) begin
                    w_state  = RUN;
                    w_cnt    = '0;
                    w_gclk   = 1'b1;
                    w_rise   = 1'b1;
                    w_per    = 2'd0;
                    w_locked = 1'b0;
                end else begin
                    w_pcnt = r_pcnt - 1'b1;
                end
            end
            RUN: begin
                if (w_wrap) begin
                    w_cnt    = '0;
                    w_per    = r_pend ? 2'd0 : (r_per == 2'd2 ? r_per : r_per + 1'b1);
                    w_locked = !r_pend && (r_locked || r_per == 2'd1);
                    if (en) begin
                        w_gclk = 1'b1;
                        w_rise = 1'b1;
                    end else begin
                        w_state  = IDLE;
                        w_locked = 1'b0;
                    end
                end else begin
                    w_cnt  = r_cnt + 1'b1;
                    w_gclk = w_cnt < w_high;
                end
            end
            default: w_state = IDLE;
        endcase
    end
    // state register; reset drops gclk immediately and discards any pending config
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_div    <= DIV_W'(DEFAULT_DIV);
            r_phase  <= '0;
            r_pend   <= 1'b0;
            r_pdiv   <= '0;
            r_pphase <= '0;
            r_cnt    <= '0;
            r_pcnt   <= '0;
            r_per    <= 2'd0;
            r_gclk   <= 1'b0;
            r_rise   <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_div    <= w_div;
            r_phase  <= w_phase;
            r_pend   <= w_pend;
            r_pdiv   <= w_pdiv;
            r_pphase <= w_pphase;
            r_cnt    <= w_cnt;
            r_pcnt   <= w_pcnt;
            r_per    <= w_per;
            r_gclk   <= w_gclk;
            r_rise   <= w_rise;
            r_locked <= w_locked;
        end
    end
endmodule

// File: tb/tb_clkdiv_gen.sv
// tb_clkdiv_gen: waveform-queue reference model with per-cycle compare plus directed literal checks
module tb_clkdiv_gen;
    localparam int DEF = 4;
    logic       mclk = 1'b0, rst = 1'b1, en = 1'b0, cfg_valid = 1'b0;
    logic [7:0] cfg_div = '0, cfg_phase = '0;
    logic       cfg_ready, gclk, gclk_rise, locked;
    int         n_cmp = 0, n_bad = 0, cyc = 0;
    int         m_mode = 0, m_div = DEF, m_phase = 0, m_wait = 0, m_done = 0, m_pdiv = 0, m_pphase = 0;
    bit         m_pend = 1'b0, m_ok = 1'b0, e_gclk = 1'b0, e_rise = 1'b0;
    bit         q[$];
    int         per, hi, ones, rises;

    clkdiv_gen #(.DIV_W(8), .DEFAULT_DIV(DEF)) dut (
        .mclk(mclk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .gclk(gclk), .gclk_rise(gclk_rise), .locked(locked)
    );

    // master clock
    always #5 mclk = ~mclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic start_period();
        q.delete();
        for (int i = 0; i < m_div; i++) q.push_back(i < (m_div + 1) / 2);
        e_gclk = q.pop_front();
        e_rise = 1'b1;
        m_mode = 2;
    endtask

    task automatic apply_pend();
        m_div   = m_pdiv;
        m_phase = m_pphase;
        m_pend  = 1'b0;
    endtask

    // reference model: each period is queued as H ones then N-H zeros
    always @(posedge mclk) begin : model
        int nd, np, pm;
        bit fire;
        cyc++;
        nd     = (cfg_div < 2) ? 2 : int'(cfg_div);
        np     = (int'(cfg_phase) >= nd) ? nd - 1 : int'(cfg_phase);
        fire   = cfg_valid && !m_pend;
        pm     = m_mode;
        e_rise = 1'b0;
        if (rst) begin
            m_mode = 0; m_div = DEF; m_phase = 0; m_pend = 1'b0; m_done = 0;
            q.delete();
            e_gclk = 1'b0;
            m_ok   = 1'b1;
        end else begin
            case (pm)
                0: begin
                    e_gclk = 1'b0;
                    if (fire) begin m_div = nd; m_phase = np; end
                    if (en) begin m_mode = 1; m_wait = m_phase; end
                end
                1: begin
                    if (!en) begin
                        m_mode = 0;
                        if (m_pend) apply_pend();
                    end else if (m_wait == 0) begin
                        m_done = 0;
                        start_period();
                    end else m_wait--;
                end
                default: begin
                    if (q.size() > 0) e_gclk = q.pop_front();
                    else begin
                        if (m_pend) begin apply_pend(); m_done = 0; end
                        else m_done++;
                        if (en) start_period();
                        else begin m_mode = 0; e_gclk = 1'b0; end
                    end
                end
            endcase
            if (fire && pm != 0) begin m_pend = 1'b1; m_pdiv = nd; m_pphase = np; end
        end
    end

    // per-cycle comparison against the model, away from the active edge
    always @(negedge mclk) begin
        if (m_ok) begin
            chk("gclk", gclk, e_gclk);
            chk("gclk_rise", gclk_rise, e_rise);
            chk("locked", locked, (m_mode == 2 && m_done >= 2));
            chk("cfg_ready", cfg_ready, !m_pend);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic wait_rise(input string nm);
        int n = 0;
        do begin tick(1); n++; end while (!gclk_rise && n < 40);
        chk(nm, gclk_rise, 1);
    endtask

    task automatic measure(output int p, output int h);
        p = 0;
        h = int'(gclk);
        while (p < 40) begin
            tick(1);
            p++;
            if (gclk_rise) break;
            h += int'(gclk);
        end
    endtask

    task automatic stop_cfg(input int d, input int p);
        en = 1'b0;
        tick(14);
        cfg_valid = 1'b1; cfg_div = 8'(d); cfg_phase = 8'(p);
        tick(1);
        chk("idle_ready", cfg_ready, 1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("rst_gclk", gclk, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_locked", locked, 0);
        chk("rst_rise", gclk_rise, 0);
        // default ratio 4, phase 0
        rst = 1'b0; en = 1'b1;
        tick(1); chk("t1_phase_gclk", gclk, 0);
        tick(1); chk("t1_first_gclk", gclk, 1); chk("t1_first_rise", gclk_rise, 1);
        tick(7); chk("t1_unlocked", locked, 0);
        tick(1); chk("t1_locked", locked, 1); chk("t1_rise2", gclk_rise, 1);
        // ratio 5, phase 2
        stop_cfg(5, 2);
        en = 1'b1;
        tick(1); chk("t2_k_gclk", gclk, 0);
        tick(2); chk("t2_k2_rise", gclk_rise, 0);
        tick(1); chk("t2_k3_rise", gclk_rise, 1);
        for (int i = 0; i < 3; i++) begin
            measure(per, hi);
            chk("t2_period", per, 5);
            chk("t2_high", hi, 3);
        end
        // live reconfiguration 4 -> 6
        stop_cfg(4, 0);
        en = 1'b1;
        wait_rise("t3_start");
        tick(8); chk("t3_locked", locked, 1); chk("t3_rise", gclk_rise, 1);
        tick(1);
        cfg_valid = 1'b1; cfg_div = 8'd6; cfg_phase = 8'd0;
        tick(1); chk("t3_ready_low", cfg_ready, 0);
        cfg_valid = 1'b0;
        tick(2);
        chk("t3_apply_rise", gclk_rise, 1);
        chk("t3_apply_unlock", locked, 0);
        chk("t3_ready_back", cfg_ready, 1);
        tick(11); chk("t3_relock_early", locked, 0);
        tick(1); chk("t3_relock", locked, 1);
        measure(per, hi);
        chk("t3_period", per, 6);
        chk("t3_high", hi, 3);
        // clamping of ratio and phase
        for (int d = 0; d < 2; d++) begin
            stop_cfg(d, 0);
            en = 1'b1;
            wait_rise("t4_start");
            measure(per, hi);
            chk("t4_clamp_period", per, 2);
            chk("t4_clamp_high", hi, 1);
        end
        stop_cfg(3, 7);
        en = 1'b1;
        tick(3); chk("t4_phase_k2", gclk_rise, 0);
        tick(1); chk("t4_phase_k3", gclk_rise, 1);
        measure(per, hi);
        chk("t4_n3_period", per, 3);
        chk("t4_n3_high", hi, 2);
        // stop mid-period with ratio 6, phase 1
        stop_cfg(6, 1);
        en = 1'b1;
        wait_rise("t5_start");
        tick(1);
        en = 1'b0;
        tick(1); chk("t5_still_high", gclk, 1);
        tick(3); chk("t5_low_end", gclk, 0);
        ones = 0; rises = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            ones += int'(gclk);
            rises += int'(gclk_rise);
        end
        chk("t5_idle_ones", ones, 0);
        chk("t5_idle_rises", rises, 0);
        en = 1'b1;
        tick(2); chk("t5_restart_k1", gclk_rise, 0);
        tick(1); chk("t5_restart_k2", gclk_rise, 1);
        // reset mid-high with a pending config
        tick(1);
        cfg_valid = 1'b1; cfg_div = 8'd3; cfg_phase = 8'd0;
        tick(1); chk("t6_pending", cfg_ready, 0); chk("t6_high", gclk, 1);
        cfg_valid = 1'b0; rst = 1'b1;
        tick(1);
        chk("t6_gclk", gclk, 0);
        chk("t6_ready", cfg_ready, 1);
        chk("t6_locked", locked, 0);
        chk("t6_rise", gclk_rise, 0);
        rst = 1'b0;
        tick(2); chk("t6_restart", gclk_rise, 1);
        for (int i = 0; i < 2; i++) begin
            measure(per, hi);
            chk("t6_period", per, DEF);
            chk("t6_high", hi, DEF / 2);
        end
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
